router_reg_p: RTL

- Parametrised successor to the router datapath register.
- Sits between the router FSM and the per-port output FIFOs.
- Captures the header, forwards header and payload words to the FIFO write bus, and holds one word in a staging register while the FIFO is full.
- Accumulates running XOR parity and counts payload words against the header length field. Reports a parity error and a length error per packet.

---
 rtl/router_reg_p.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/router_reg_p.sv
// Datapath register between the router FSM and the per-port output FIFOs: header capture,
// FIFO write bus, one-word staging on full, parity/length checks. Option: ROUTER_REG_STATS_EN.
module router_reg_p #(
  parameter  int unsigned DW     = 8,
  parameter  int unsigned ADDR_W = 2,
  localparam int unsigned LEN_W  = DW - ADDR_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [DW-1:0]    i_data_in,
  input  logic             i_pkt_vld,
  input  logic             i_f_full,
  input  logic             i_detect_add,
  input  logic             i_lfd_state,
  input  logic             i_ld_state,
  input  logic             i_laf_state,
  input  logic             i_full_state,
  input  logic             i_rst_int_reg,
  output logic [DW-1:0]    o_dout,
  output logic             o_dout_vld,
  output logic             o_parity_done,
  output logic             o_low_pkt_vld,
  output logic             o_err,
  output logic             o_len_err,
`ifdef ROUTER_REG_STATS_EN
  output logic [15:0]      o_pkt_cnt,
  output logic [15:0]      o_err_cnt,
`endif
  output logic [LEN_W-1:0] o_pkt_len
);

  logic [DW-1:0]    r_dout, w_dout_d;
  logic             r_dout_vld, w_dout_vld_d;
  logic             r_parity_done, w_parity_done_d;
  logic             r_low_pkt_vld, w_low_pkt_vld_d;
  logic             r_err, w_err_d;
  logic             r_len_err, w_len_err_d;
  logic [LEN_W-1:0] r_pkt_len, w_pkt_len_d;
  logic [DW-1:0]    r_hdr, w_hdr_d;
  logic [DW-1:0]    r_ffb, w_ffb_d;
  logic             r_ffb_vld, w_ffb_vld_d;
  logic [DW-1:0]    r_cal_par, w_cal_par_d;
  logic [DW-1:0]    r_pkt_par, w_pkt_par_d;
  logic [LEN_W-1:0] r_byte_cnt, w_byte_cnt_d;
  logic             r_pd_prev;
  logic             w_pd_rise;

  // Errors are evaluated once, in the first cycle parity_done is seen high.
  assign w_pd_rise = r_parity_done & ~r_pd_prev;

  always_comb begin
    w_dout_d        = r_dout;
    w_dout_vld_d    = 1'b0;
    w_parity_done_d = r_parity_done;
    w_low_pkt_vld_d = r_low_pkt_vld;
    w_err_d         = r_err;
    w_len_err_d     = r_len_err;
    w_pkt_len_d     = r_pkt_len;
    w_hdr_d         = r_hdr;
    w_ffb_d         = r_ffb;
    w_ffb_vld_d     = r_ffb_vld;
    w_cal_par_d     = r_cal_par;
    w_pkt_par_d     = r_pkt_par;
    w_byte_cnt_d    = r_byte_cnt;

    if (i_detect_add) begin
      w_cal_par_d     = '0;
      w_ffb_d         = '0;
      w_ffb_vld_d     = 1'b0;
      w_pkt_par_d     = '0;
      w_byte_cnt_d    = '0;
      w_parity_done_d = 1'b0;
      w_err_d         = 1'b0;
      w_len_err_d     = 1'b0;
      if (i_pkt_vld) begin
        w_hdr_d     = i_data_in;
        w_pkt_len_d = i_data_in[DW-1:ADDR_W];
      end
    end else if (i_lfd_state) begin
      w_dout_d     = r_hdr;
      w_dout_vld_d = 1'b1;
      w_cal_par_d  = r_cal_par ^ r_hdr;
    end else if (i_ld_state) begin
      if (i_pkt_vld && !i_full_state) begin
        w_cal_par_d = r_cal_par ^ i_data_in;
        if (&r_byte_cnt) begin
          w_len_err_d = 1'b1;
        end else begin
          w_byte_cnt_d = r_byte_cnt + LEN_W'(1);
        end
        if (!i_f_full) begin
          w_dout_d     = i_data_in;
          w_dout_vld_d = 1'b1;
        end else begin
          // Park the word until the FIFO drains; laf_state replays it.
          w_ffb_d     = i_data_in;
          w_ffb_vld_d = 1'b1;
        end
      end else if (!i_pkt_vld) begin
        w_pkt_par_d     = i_data_in;
        w_low_pkt_vld_d = 1'b1;
        if (!i_f_full) begin
          w_parity_done_d = 1'b1;
        end
      end
    end else if (i_laf_state) begin
      w_dout_d     = r_ffb;
      w_dout_vld_d = r_ffb_vld;
      w_ffb_vld_d  = 1'b0;
      if (r_low_pkt_vld && !r_parity_done) begin
        w_parity_done_d = 1'b1;
      end
    end

    if (i_rst_int_reg) begin
      w_low_pkt_vld_d = 1'b0;
      if (!i_pkt_vld) begin
        w_cal_par_d = '0;
      end
    end

    if (!i_detect_add && w_pd_rise) begin
      w_err_d     = (r_cal_par != r_pkt_par);
      w_len_err_d = w_len_err_d | (r_byte_cnt != r_pkt_len);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout        <= '0;
      r_dout_vld    <= 1'b0;
      r_parity_done <= 1'b0;
      r_low_pkt_vld <= 1'b0;
      r_err         <= 1'b0;
      r_len_err     <= 1'b0;
      r_pkt_len     <= '0;
      r_hdr         <= '0;
      r_ffb         <= '0;
      r_ffb_vld     <= 1'b0;
      r_cal_par     <= '0;
      r_pkt_par     <= '0;
      r_byte_cnt    <= '0;
      r_pd_prev     <= 1'b0;
    end else begin
      r_dout        <= w_dout_d;
      r_dout_vld    <= w_dout_vld_d;
      r_parity_done <= w_parity_done_d;
      r_low_pkt_vld <= w_low_pkt_vld_d;
      r_err         <= w_err_d;
      r_len_err     <= w_len_err_d;
      r_pkt_len     <= w_pkt_len_d;
      r_hdr         <= w_hdr_d;
      r_ffb         <= w_ffb_d;
      r_ffb_vld     <= w_ffb_vld_d;
      r_cal_par     <= w_cal_par_d;
      r_pkt_par     <= w_pkt_par_d;
      r_byte_cnt    <= w_byte_cnt_d;
      r_pd_prev     <= r_parity_done;
    end
  end

`ifdef ROUTER_REG_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_err_cnt;
  logic        w_err_new;

  // Both error flags are sticky per packet, so "either newly set" counts a packet once.
  assign w_err_new = (w_err_d | w_len_err_d) & ~(r_err | r_len_err);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_pd_rise && (r_pkt_cnt != 16'hFFFF)) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
      if (w_err_new && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign o_pkt_cnt = r_pkt_cnt;
  assign o_err_cnt = r_err_cnt;
`endif

  assign o_dout        = r_dout;
  assign o_dout_vld    = r_dout_vld;
  assign o_parity_done = r_parity_done;
  assign o_low_pkt_vld = r_low_pkt_vld;
  assign o_err         = r_err;
  assign o_len_err     = r_len_err;
  assign o_pkt_len     = r_pkt_len;

endmodule
